// File: rtl/pwm_capture.sv
// pwm_capture: measures PWM period and high time, flags dead inputs.
// Optional glitch filter on the synchronized input: PWM_CAPTURE_FILTER_EN.

module pwm_capture #(
  parameter int CNT_W    = 16,
  parameter int TIMEOUT  = 1000,
  parameter int FILT_LEN = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] period_count,
  output logic [CNT_W-1:0] high_count,
  output logic             meas_valid,
  output logic             timeout,
  output logic             stuck_level
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] MEAS = 2'd2;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_MAX = CNT_W'(TIMEOUT);

  logic [1:0]       sync_q, sync_d;
  logic             lvl;
  logic             lvl_d_q, lvl_d_d;
  logic             rise, fall, tmo_hit, pub;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] per_out_q, per_out_d;
  logic [CNT_W-1:0] hi_out_q, hi_out_d;
  logic             valid_q, valid_d;
  logic             tmo_q, tmo_d;
  logic             stuck_q, stuck_d;

  assign sync_d = {sync_q[0], pwm_in};

  // Two-stage synchronizer, idles high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) sync_q <= 2'b11;
    else          sync_q <= sync_d;
  end

`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FW = $clog2(FILT_LEN + 1);

  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          filt_q, filt_d;

  // Accept a new level only after FILT_LEN agreeing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync_q[1] != filt_q) begin
      if (fcnt_q == FW'(FILT_LEN - 1)) filt_d = sync_q[1];
      else fcnt_d = fcnt_q + 1'b1;
    end
  end

  // Filter state
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync_q[1];
`endif

  assign lvl_d_d = lvl;
  assign rise    = lvl & ~lvl_d_q;
  assign fall    = ~lvl & lvl_d_q;
  assign tmo_hit = (gap_q == GAP_MAX);

  // Period, high-time and constant-level run counters
  always_comb begin
    per_d = per_q;
    hi_d  = hi_q;
    gap_d = gap_q;
    if (rise) begin
      per_d = CNT_ONE;
      hi_d  = CNT_ONE;
    end else begin
      if (per_q != CNT_MAX) per_d = per_q + CNT_ONE;
      if (lvl && hi_q != CNT_MAX) hi_d = hi_q + CNT_ONE;
    end
    if (rise || fall) gap_d = '0;
    else if (gap_q != GAP_MAX) gap_d = gap_q + CNT_ONE;
  end

  // Arming FSM; timeout overrides everything
  always_comb begin
    state_d = state_q;
    pub     = 1'b0;
    if (tmo_hit) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE:    if (!lvl) state_d = ARM;
        ARM:     if (rise) state_d = MEAS;
        MEAS:    pub = rise;
        default: state_d = IDLE;
      endcase
    end
  end

  // Published outputs; stuck level is the run's level, not the edge ending it
  always_comb begin
    per_out_d = pub ? per_q : per_out_q;
    hi_out_d  = pub ? hi_q  : hi_out_q;
    valid_d   = pub;
    tmo_d     = tmo_q;
    stuck_d   = stuck_q;
    if (tmo_hit) begin
      tmo_d   = 1'b1;
      stuck_d = lvl_d_q;
    end else if (pub) begin
      tmo_d   = 1'b0;
    end
  end

  // Main state registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      lvl_d_q   <= 1'b1;
      state_q   <= IDLE;
      per_q     <= '0;
      hi_q      <= '0;
      gap_q     <= '0;
      per_out_q <= '0;
      hi_out_q  <= '0;
      valid_q   <= 1'b0;
      tmo_q     <= 1'b0;
      stuck_q   <= 1'b0;
    end else begin
      lvl_d_q   <= lvl_d_d;
      state_q   <= state_d;
      per_q     <= per_d;
      hi_q      <= hi_d;
      gap_q     <= gap_d;
      per_out_q <= per_out_d;
      hi_out_q  <= hi_out_d;
      valid_q   <= valid_d;
      tmo_q     <= tmo_d;
      stuck_q   <= stuck_d;
    end
  end

  assign period_count = per_out_q;
  assign high_count   = hi_out_q;
  assign meas_valid   = valid_q;
  assign timeout      = tmo_q;
  assign stuck_level  = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: random and directed PWM stimulus against an
// event-level model of period, high time and timeout behaviour.

module tb_pwm_capture;

  localparam int CNT_W    = 16;
  localparam int TIMEOUT  = 1000;
  localparam int FILT_LEN = 3;
  localparam int CMAX     = (1 << CNT_W) - 1;

  logic             clock   = 1'b0;
  logic             reset_n = 1'b0;
  logic             pwm_in  = 1'b0;
  logic [CNT_W-1:0] period_count;
  logic [CNT_W-1:0] high_count;
  logic             meas_valid;
  logic             timeout;
  logic             stuck_level;

  pwm_capture #(
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT),
    .FILT_LEN(FILT_LEN)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .pwm_in      (pwm_in),
    .period_count(period_count),
    .high_count  (high_count),
    .meas_valid  (meas_valid),
    .timeout     (timeout),
    .stuck_level (stuck_level)
  );

  always #5 clock = ~clock;

  int total   = 0;
  int bad     = 0;
  int strobes = 0;
  int hi1_cnt = 0;

  // model: sample history, prefix sum of high cycles, event times
  int c;
  bit s_q[$];
  int ones_q[$];
  int m_last_edge;
  int m_last_rise;
  int m_rises;
  bit m_low;
  bit m_lp;
  bit m_filt;
  int m_per;
  int m_hi;
  bit m_mv;
  bit m_to;
  bit m_st;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // synchronized level: sample from two edges back, high before that
  function automatic bit raw_at(input int j);
    if (j < 2) return 1'b1;
    return s_q[j-2];
  endfunction

  task automatic model_reset();
    c = 0;
    s_q.delete();
    ones_q.delete();
    ones_q.push_back(0);
    m_last_edge = -1;
    m_last_rise = 0;
    m_rises = 0;
    m_low = 1'b0;
    m_lp = 1'b1;
    m_filt = 1'b1;
    m_per = 0;
    m_hi = 0;
    m_mv = 1'b0;
    m_to = 1'b0;
    m_st = 1'b0;
    strobes = 0;
  endtask

  task automatic model_step();
    int j;
    bit lv, rise, fall, tmo, pub;
`ifdef PWM_CAPTURE_FILTER_EN
    bit flip;
`endif
    j = c;
`ifdef PWM_CAPTURE_FILTER_EN
    lv = m_filt;
    flip = 1'b1;
    for (int k = 0; k < FILT_LEN; k++)
      if (raw_at(j - k) == m_filt) flip = 1'b0;
    if (flip) m_filt = !m_filt;
`else
    lv = raw_at(j);
`endif
    rise = lv && !m_lp;
    fall = !lv && m_lp;
    tmo  = (j - m_last_edge - 1) >= TIMEOUT;
    pub  = !tmo && rise && m_low && (m_rises >= 1);
    if (pub) begin
      m_per = sat(j - m_last_rise);
      m_hi  = sat(ones_q[j] - ones_q[m_last_rise]);
    end
    m_mv = pub;
    if (tmo) begin
      m_to = 1'b1;
      m_st = m_lp;
      m_low = 1'b0;
      m_rises = 0;
    end else begin
      if (pub) m_to = 1'b0;
      if (rise && m_low) m_rises++;
      if (!lv) m_low = 1'b1;
    end
    if (rise || fall) m_last_edge = j;
    if (rise) m_last_rise = j;
    ones_q.push_back(ones_q[j] + int'(lv));
    m_lp = lv;
  endtask

  // per-cycle compare against the model
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        model_reset();
      end else begin
        s_q.push_back(pwm_in);
        model_step();
        c++;
      end
      check("valid",  32'(meas_valid),   32'(m_mv));
      check("period", 32'(period_count), 32'(m_per));
      check("high",   32'(high_count),   32'(m_hi));
      check("tmo",    32'(timeout),      32'(m_to));
      check("stuck",  32'(stuck_level),  32'(m_st));
      if (reset_n && meas_valid === 1'b1) begin
        strobes++;
        if (high_count == 1) hi1_cnt++;
      end
    end
  end

  task automatic drive(input bit v, input int n);
    repeat (n) begin
      @(negedge clock);
      #1;
      pwm_in = v;
    end
  endtask

  task automatic do_reset(input bit v, input int n);
    reset_n = 1'b0;
    pwm_in = v;
    repeat (n) @(negedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  function automatic int pick();
    int r;
    r = int'($urandom_range(0, 99));
    if (r < 3) return TIMEOUT - 2 + int'($urandom_range(0, 4));
    return int'($urandom_range(1, 25));
  endfunction

  int h1;

  initial begin
    repeat (3) @(negedge clock);
    #1;
    check("rst_period", 32'(period_count), 0);
    check("rst_tmo",    32'(timeout),      0);
    reset_n = 1'b1;

    drive(0, 5);
    repeat (6) begin drive(1, 5); drive(0, 5); end
    check("p55_strobes", strobes, 5);
    check("p55_period",  32'(period_count), 10);
    check("p55_high",    32'(high_count),   5);
    check("mdl_p55_per", m_per, 10);
    check("mdl_p55_hi",  m_hi,  5);

    repeat (3) begin drive(1, 6); drive(0, 4); end
    check("p64_strobes", strobes, 8);
    check("p64_period",  32'(period_count), 10);
    check("p64_high",    32'(high_count),   6);

    drive(1, 1000); drive(0, 5); drive(1, 5); drive(0, 5);
    check("h1000_strobes", strobes, 10);
    check("h1000_period",  32'(period_count), 1005);
    check("h1000_high",    32'(high_count),   1000);
    check("h1000_tmo",     32'(timeout),      0);
    check("mdl_h1000_hi",  m_hi, 1000);

    drive(1, 1001); drive(0, 8);
    check("h1001_strobes", strobes, 11);
    check("h1001_tmo",     32'(timeout),     1);
    check("h1001_stuck",   32'(stuck_level), 1);
    check("h1001_period",  32'(period_count), 10);
    check("mdl_h1001_st",  32'(m_st), 1);

    repeat (3) begin drive(1, 5); drive(0, 5); end
    check("resume_strobes", strobes, 13);
    check("resume_tmo",     32'(timeout), 0);
    check("resume_high",    32'(high_count), 5);

    do_reset(0, 2);
    drive(0, 1010);
    check("low_tmo",     32'(timeout),      1);
    check("low_stuck",   32'(stuck_level),  0);
    check("low_period",  32'(period_count), 0);
    check("low_high",    32'(high_count),   0);
    check("low_strobes", strobes, 0);

    repeat (2) begin drive(1, 5); drive(0, 5); end
    drive(1, 3);
    reset_n = 1'b0;
    #1;
    check("arst_period", 32'(period_count), 0);
    check("arst_tmo",    32'(timeout),      0);
    check("arst_valid",  32'(meas_valid),   0);
    repeat (2) @(negedge clock);
    #1;
    reset_n = 1'b1;
    drive(1, 20);
    check("arst_hold_strobes", strobes, 0);
    drive(0, 5); drive(1, 5); drive(0, 5); drive(1, 5); drive(0, 5);
    check("arst_strobes", strobes, 1);
    check("arst_per",     32'(period_count), 10);

    repeat (3) begin drive(1, 10); drive(0, 10); end
    h1 = hi1_cnt;
    drive(1, 10); drive(0, 4); drive(1, 1); drive(0, 5);
    repeat (2) begin drive(1, 10); drive(0, 10); end
`ifdef PWM_CAPTURE_FILTER_EN
    check("glitch_hi1", hi1_cnt - h1, 0);
`else
    check("glitch_hi1", hi1_cnt - h1, 1);
`endif
    check("glitch_period", 32'(period_count), 20);
    check("glitch_high",   32'(high_count),   10);

    repeat (250) begin
      drive(1, pick());
      drive(0, pick());
    end
    drive(0, 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
